// File: rtl/pit_timer_array_if.sv
// Host register bus of the interval timer array: active-low chip select and
// strobes, address, write data and the registered read data.
interface pit_timer_array_if #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 3
);
   logic              CS;
   logic              WR;
   logic              RD;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  wdata;
   logic [CNT_W-1:0]  rdata;

   modport master (
      output CS, WR, RD, addr, wdata,
      input  rdata
   );

   modport slave (
      input  CS, WR, RD, addr, wdata,
      output rdata
   );
endinterface

// File: rtl/pit_timer_array.sv
// Array of NUM_CH independent 8254-style down-counters behind one host bus.
// Each channel counts on its own tick enable; out/tc/rdata are registered.
module pit_timer_array #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   pit_timer_array_if.slave  bus,
   input  logic [NUM_CH-1:0] tick,
   input  logic [NUM_CH-1:0] gate,
   output logic [NUM_CH-1:0] out,
   output logic [NUM_CH-1:0] tc
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT} state_e;

   localparam logic [1:0] M_INT     = 2'd0;
   localparam logic [1:0] M_ONESHOT = 2'd1;
   localparam logic [1:0] M_RATE    = 2'd2;

   state_e                       st_q [NUM_CH];
   state_e                       st_d [NUM_CH];
   logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
   logic [NUM_CH-1:0][CNT_W-1:0] reload_q, reload_d;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]            null_q, null_d;
   logic [NUM_CH-1:0]            out_q, out_d;
   logic [NUM_CH-1:0]            tc_q, tc_d;
   logic [NUM_CH-1:0]            trig_q, trig_d;
   logic [NUM_CH-1:0]            gate_prev_q, gate_prev_d;
   logic [CNT_W-1:0]             rdata_q, rdata_d;
   logic                         wr_en, rd_en;

   // A count value of 0 stands for 2^CNT_W, so widen by one bit to compare.
   function automatic logic [CNT_W:0] ext_val(input logic [CNT_W-1:0] v);
      return (v == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, v};
   endfunction

   // Square-wave output level: high while count > floor(N/2).
   function automatic logic sq_high(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] n);
      return ext_val(c) > (ext_val(n) >> 1);
   endfunction

   assign wr_en = ~bus.CS & ~bus.WR;
   assign rd_en = ~bus.CS & ~bus.RD & bus.WR;

   // Per-channel next state: host writes first, then gate/tick driven counting.
   always_comb begin
      gate_prev_d = gate;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         st_d[ch]     = st_q[ch];
         mode_d[ch]   = mode_q[ch];
         reload_d[ch] = reload_q[ch];
         cnt_d[ch]    = cnt_q[ch];
         null_d[ch]   = null_q[ch];
         out_d[ch]    = out_q[ch];
         trig_d[ch]   = trig_q[ch];
         tc_d[ch]     = 1'b0;
         if (wr_en && bus.addr == ADDR_W'(2 * ch + 1)) begin
            mode_d[ch] = bus.wdata[1:0];
            st_d[ch]   = S_IDLE;
            out_d[ch]  = (bus.wdata[1:0] != M_INT);
            null_d[ch] = 1'b1;
            trig_d[ch] = 1'b0;
         end else if (wr_en && bus.addr == ADDR_W'(2 * ch)) begin
            // A write on the terminal tick wins, so no tc that cycle.
            reload_d[ch] = bus.wdata;
            null_d[ch]   = 1'b1;
            if (mode_q[ch] != M_ONESHOT) st_d[ch] = S_LOAD;
            if (mode_q[ch] == M_INT) out_d[ch] = 1'b0;
         end else if (mode_q[ch] == M_ONESHOT) begin
            // Gate rising edge arms a trigger that the next tick consumes.
            if (tick[ch] && trig_q[ch]) begin
               cnt_d[ch]  = reload_q[ch];
               out_d[ch]  = 1'b0;
               null_d[ch] = 1'b0;
               st_d[ch]   = S_COUNT;
               trig_d[ch] = gate[ch] & ~gate_prev_q[ch];
            end else begin
               trig_d[ch] = trig_q[ch] | (gate[ch] & ~gate_prev_q[ch]);
               if (tick[ch] && st_q[ch] == S_COUNT) begin
                  cnt_d[ch] = cnt_q[ch] - 1'b1;
                  if (cnt_q[ch] == CNT_W'(1)) begin
                     out_d[ch] = 1'b1;
                     tc_d[ch]  = 1'b1;
                     st_d[ch]  = S_IDLE;
                  end
               end
            end
         end else begin
            unique case (st_q[ch])
               S_LOAD: begin
                  if (tick[ch] && gate[ch]) begin
                     cnt_d[ch]  = reload_q[ch];
                     null_d[ch] = 1'b0;
                     st_d[ch]   = S_COUNT;
                     out_d[ch]  = (mode_q[ch] != M_INT);
                  end
               end
               S_COUNT: begin
                  if (mode_q[ch] != M_INT && !gate[ch]) begin
                     out_d[ch] = 1'b1;
                     st_d[ch]  = S_LOAD;
                  end else if (tick[ch] && gate[ch]) begin
                     if (mode_q[ch] == M_INT) begin
                        // Keeps counting through the wrap; tc only on first terminal.
                        cnt_d[ch] = cnt_q[ch] - 1'b1;
                        if (cnt_q[ch] == CNT_W'(1) && !out_q[ch]) begin
                           out_d[ch] = 1'b1;
                           tc_d[ch]  = 1'b1;
                        end
                     end else if (cnt_q[ch] == CNT_W'(1)) begin
                        cnt_d[ch] = reload_q[ch];
                        tc_d[ch]  = 1'b1;
                        out_d[ch] = 1'b1;
                     end else begin
                        cnt_d[ch] = cnt_q[ch] - 1'b1;
                        out_d[ch] = (mode_q[ch] == M_RATE) ? (cnt_q[ch] != CNT_W'(2))
                                  : sq_high(CNT_W'(cnt_q[ch] - 1'b1), reload_q[ch]);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Read mux: live count or status word, captured only on a read strobe.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.addr == ADDR_W'(2 * ch)) begin
               rdata_d = cnt_q[ch];
            end else if (bus.addr == ADDR_W'(2 * ch + 1)) begin
               rdata_d = CNT_W'({null_q[ch], out_q[ch], mode_q[ch]});
            end
         end
      end
   end

   // State registers; reset aborts any count in progress immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int ch = 0; ch < NUM_CH; ch++) st_q[ch] <= S_IDLE;
         mode_q      <= '0;
         reload_q    <= '0;
         cnt_q       <= '0;
         null_q      <= '1;
         out_q       <= '0;
         tc_q        <= '0;
         trig_q      <= '0;
         gate_prev_q <= '0;
         rdata_q     <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) st_q[ch] <= st_d[ch];
         mode_q      <= mode_d;
         reload_q    <= reload_d;
         cnt_q       <= cnt_d;
         null_q      <= null_d;
         out_q       <= out_d;
         tc_q        <= tc_d;
         trig_q      <= trig_d;
         gate_prev_q <= gate_prev_d;
         rdata_q     <= rdata_d;
      end
   end

   assign out       = out_q;
   assign tc        = tc_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_pit_timer_array.sv
// Directed bench for pit_timer_array: expected out/tc waveforms and read data
// are queued as stimulus is applied and popped as each clock edge completes.
module tb_pit_timer_array;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 16;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] gate;
   logic [NUM_CH-1:0] out;
   logic [NUM_CH-1:0] tc;

   pit_timer_array_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus_if ();

   pit_timer_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .tick (tick),
      .gate (gate),
      .out  (out),
      .tc   (tc)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_fail  = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_total++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0h required=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) n_pass++;
         else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // '0' = out low, '1' = out high, 'T' = out high with tc pulse, per edge.
   task automatic run_seq(input int ch, input string tag, input string s);
      logic [31:0] v;
      byte         c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c == "T")      v = 32'd3;
         else if (c == "1") v = 32'd2;
         else               v = 32'd0;
         push($sformatf("%s[%0d]", tag, i), v);
         step();
         check({30'b0, out[ch], tc[ch]});
      end
   endtask

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] d);
      bus_if.CS    = 1'b0;
      bus_if.WR    = 1'b0;
      bus_if.addr  = a;
      bus_if.wdata = d;
      step();
      bus_if.CS = 1'b1;
      bus_if.WR = 1'b1;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] exp_v,
                           input string tag);
      push(tag, 32'(exp_v));
      bus_if.CS   = 1'b0;
      bus_if.RD   = 1'b0;
      bus_if.addr = a;
      step();
      bus_if.CS = 1'b1;
      bus_if.RD = 1'b1;
      check(32'(bus_if.rdata));
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      bus_if.CS    = 1'b1;
      bus_if.WR    = 1'b1;
      bus_if.RD    = 1'b1;
      bus_if.addr  = '0;
      bus_if.wdata = '0;
      tick         = '0;
      gate         = '0;
      step();
      step();
      push("rst_out", 0);   check(32'(out));
      push("rst_tc", 0);    check(32'(tc));
      push("rst_rdata", 0); check(32'(bus_if.rdata));
      rst = 1'b0;
      step();
      // Status word {null_count, out, mode}: null=1 after reset
      bus_read(3'd1, 16'h0008, "rst_ctrl0");

      // Mode 0, ch0, count 5
      bus_write(3'd1, 16'd0);
      bus_write(3'd0, 16'd5);
      gate[0] = 1'b1;
      tick[0] = 1'b1;
      run_seq(0, "m0", "00000T1");
      tick[0] = 1'b0;
      bus_read(3'd0, 16'hFFFF, "m0_wrap");
      bus_read(3'd1, 16'h0004, "m0_ctrl");

      // Mode 2, ch1, count 4, then gate drop and return
      bus_write(3'd3, 16'd2);
      bus_write(3'd2, 16'd4);
      gate[1] = 1'b1;
      tick[1] = 1'b1;
      run_seq(1, "m2", "1110T110T110");
      gate[1] = 1'b0;
      run_seq(1, "m2_gate", "111");
      gate[1] = 1'b1;
      run_seq(1, "m2_resume", "1110T");
      tick[1] = 1'b0;

      // Mode 3, ch2, count 5 then count 4
      bus_write(3'd5, 16'd3);
      bus_write(3'd4, 16'd5);
      gate[2] = 1'b1;
      tick[2] = 1'b1;
      run_seq(2, "m3_n5", "11100T1100T");
      tick[2] = 1'b0;
      bus_write(3'd4, 16'd4);
      tick[2] = 1'b1;
      run_seq(2, "m3_n4", "1100T100T");
      tick[2] = 1'b0;

      // Mode 1, ch0, count 3: single shot, then a retrigger mid-count
      bus_write(3'd1, 16'd1);
      bus_write(3'd0, 16'd3);
      gate[0] = 1'b0;
      tick[0] = 1'b1;
      run_seq(0, "m1_idle", "11");
      gate[0] = 1'b1;
      run_seq(0, "m1_trig", "1");
      gate[0] = 1'b0;
      run_seq(0, "m1_shot", "000T1");
      gate[0] = 1'b1;
      run_seq(0, "m1_rt_trig", "1");
      gate[0] = 1'b0;
      run_seq(0, "m1_rt_load", "0");
      gate[0] = 1'b1;
      run_seq(0, "m1_rt_again", "0");
      gate[0] = 1'b0;
      run_seq(0, "m1_rt_run", "000T1");
      tick[0] = 1'b0;

      // COUNT write landing on the terminal tick suppresses tc
      bus_write(3'd1, 16'd0);
      bus_write(3'd0, 16'd2);
      gate[0] = 1'b1;
      tick[0] = 1'b1;
      run_seq(0, "wr_tc_pre", "00");
      bus_if.CS    = 1'b0;
      bus_if.WR    = 1'b0;
      bus_if.addr  = 3'd0;
      bus_if.wdata = 16'd2;
      run_seq(0, "wr_tc_hit", "0");
      bus_if.CS = 1'b1;
      bus_if.WR = 1'b1;
      run_seq(0, "wr_tc_post", "00T");
      tick[0] = 1'b0;

      // Unmapped addresses
      bus_write(3'd7, 16'hABCD);
      bus_read(3'd7, 16'h0000, "addr7");
      bus_read(3'd6, 16'h0000, "addr6");
      bus_read(3'd1, 16'h0004, "addr7_noside");

      // WR and RD low together: write taken, rdata held
      bus_read(3'd4, 16'h0004, "ch2_cnt");
      bus_if.CS    = 1'b0;
      bus_if.WR    = 1'b0;
      bus_if.RD    = 1'b0;
      bus_if.addr  = 3'd5;
      bus_if.wdata = 16'd2;
      step();
      bus_if.CS = 1'b1;
      bus_if.WR = 1'b1;
      bus_if.RD = 1'b1;
      push("wrrd_hold", 32'h4);
      check(32'(bus_if.rdata));
      bus_read(3'd5, 16'h000E, "wrrd_ctrl");

      // Reset asserted mid-count
      bus_write(3'd1, 16'd0);
      bus_write(3'd0, 16'd10);
      tick[0] = 1'b1;
      run_seq(0, "pre_rst", "000");
      rst = 1'b1;
      #1;
      push("rst_mid_out", 0);   check(32'(out));
      push("rst_mid_tc", 0);    check(32'(tc));
      push("rst_mid_rdata", 0); check(32'(bus_if.rdata));
      step();
      rst = 1'b0;
      bus_read(3'd1, 16'h0008, "rst_mid_ctrl");
      bus_read(3'd0, 16'h0000, "rst_mid_cnt");

      // Reload 0 in mode 0 means 2^16 ticks to terminal count
      bus_write(3'd0, 16'd0);
      run_seq(0, "big_load", "0");
      n = 0;
      do begin
         step();
         n++;
      end while (tc[0] !== 1'b1 && n < 70000);
      push("big_count", 32'd65536);
      check(32'(n));
      tick = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
